// File: rtl/msg_send_intf_if.sv
// Packet-in / SAP-message-out signal bundle for msg_send_intf.
// The master side is the transmitter; the slave side is the packet source plus send queue.
interface msg_send_intf_if #(
   parameter int unsigned C_NUM_FLITS = 4
);
   logic                       pkt_valid;
   logic                       pkt_accept;
   logic [C_NUM_FLITS*128-1:0] pkt_data;
   logic [15:0]                pkt_target;
   logic [9:0]                 pkt_id;
   logic [7:0]                 req_type;
   logic [9:0]                 req_length;
   logic [15:0]                req_target;
   logic [9:0]                 req_id;
   logic [6:0]                 req_error;
   logic                       req_valid;
   logic                       req_complete;
   logic [127:0]               req_data;
   logic                       req_data_valid;
   logic                       req_data_ready;

   modport master (
      input  pkt_valid, pkt_data, pkt_target, pkt_id, req_complete, req_data_ready,
      output pkt_accept, req_type, req_length, req_target, req_id, req_error, req_valid,
             req_data, req_data_valid
   );

   modport slave (
      output pkt_valid, pkt_data, pkt_target, pkt_id, req_complete, req_data_ready,
      input  pkt_accept, req_type, req_length, req_target, req_id, req_error, req_valid,
             req_data, req_data_valid
   );
endinterface

// File: rtl/msg_send_intf.sv
// Latches one wide packet and serialises it as a single SAP message (header + 128b flits),
// then waits for the send queue's completion with a timeout.
module msg_send_intf #(
   parameter int unsigned C_NUM_FLITS      = 4,
   parameter logic [7:0]  C_MSG_TYPE       = 8'h03,
   parameter int unsigned C_TIMEOUT_CYCLES = 1024
) (
   input  logic            clk,
   input  logic            rst,
   msg_send_intf_if.master bus,
   output logic            busy,
   output logic            err_timeout
);

   localparam int unsigned CntW = (C_NUM_FLITS > 1) ? $clog2(C_NUM_FLITS) : 1;
   localparam int unsigned TmrW = $clog2(C_TIMEOUT_CYCLES);
   localparam int unsigned BufW = C_NUM_FLITS * 128;
   localparam logic [CntW-1:0] LastFlit = CntW'(C_NUM_FLITS - 1);
   localparam logic [TmrW-1:0] LastTick = TmrW'(C_TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StData, StWait} state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [TmrW-1:0] timer_q;
   logic [BufW-1:0] flit_buf_q;
   logic [127:0]    req_data_q;
   logic [15:0]     req_target_q;
   logic [9:0]      req_id_q;
   logic [7:0]      req_type_q;
   logic [9:0]      req_length_q;
   logic            req_valid_q;
   logic            req_data_valid_q;
   logic            busy_q;
   logic            err_timeout_q;

   // Buffer keeps the not-yet-presented flits in its low bits; the next flit is always at [127:0].
   logic [BufW-1:0] buf_shift;
   assign buf_shift = flit_buf_q >> 128;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= StIdle;
         cnt_q            <= '0;
         timer_q          <= '0;
         flit_buf_q       <= '0;
         req_data_q       <= '0;
         req_target_q     <= '0;
         req_id_q         <= '0;
         req_type_q       <= '0;
         req_length_q     <= '0;
         req_valid_q      <= 1'b0;
         req_data_valid_q <= 1'b0;
         busy_q           <= 1'b0;
         err_timeout_q    <= 1'b0;
      end else begin
         err_timeout_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.pkt_valid) begin
                  flit_buf_q       <= bus.pkt_data;
                  req_data_q       <= bus.pkt_data[127:0];
                  req_target_q     <= bus.pkt_target;
                  req_id_q         <= bus.pkt_id;
                  req_type_q       <= C_MSG_TYPE;
                  req_length_q     <= 10'(C_NUM_FLITS * 16);
                  req_valid_q      <= 1'b1;
                  req_data_valid_q <= 1'b1;
                  busy_q           <= 1'b1;
                  cnt_q            <= '0;
                  timer_q          <= '0;
                  state_q          <= StData;
               end
            end
            StData: begin
               if (bus.req_data_ready) begin
                  if (cnt_q == LastFlit) begin
                     req_data_valid_q <= 1'b0;
                     cnt_q            <= '0;
                     state_q          <= StWait;
                  end else begin
                     cnt_q      <= cnt_q + CntW'(1);
                     flit_buf_q <= buf_shift;
                     req_data_q <= buf_shift[127:0];
                  end
               end
            end
            StWait: begin
               // Completion takes priority over a coincident timeout.
               if (bus.req_complete) begin
                  req_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  timer_q     <= '0;
                  state_q     <= StIdle;
               end else if (timer_q == LastTick) begin
                  err_timeout_q <= 1'b1;
                  req_valid_q   <= 1'b0;
                  busy_q        <= 1'b0;
                  timer_q       <= '0;
                  state_q       <= StIdle;
               end else begin
                  timer_q <= timer_q + TmrW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.pkt_accept     = (state_q == StIdle) && !rst;
   assign bus.req_type       = req_type_q;
   assign bus.req_length     = req_length_q;
   assign bus.req_target     = req_target_q;
   assign bus.req_id         = req_id_q;
   assign bus.req_error      = 7'd0;
   assign bus.req_valid      = req_valid_q;
   assign bus.req_data       = req_data_q;
   assign bus.req_data_valid = req_data_valid_q;
   assign busy               = busy_q;
   assign err_timeout        = err_timeout_q;

endmodule

// File: tb/tb_msg_send_intf.sv
// Bench for msg_send_intf: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (queue of pending flits, wait-cycle count).
module tb_msg_send_intf;

   localparam int NF = 4;
   localparam int TO = 16;
   localparam logic [7:0] MT = 8'h03;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy, err_timeout;

   msg_send_intf_if #(.C_NUM_FLITS(NF)) bus ();

   msg_send_intf #(
      .C_NUM_FLITS     (NF),
      .C_MSG_TYPE      (MT),
      .C_TIMEOUT_CYCLES(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .busy       (busy),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int beats, accepts, errs;

   // Model state
   logic [127:0] m_flits[$];
   bit           m_active = 1'b0;
   bit           m_err = 1'b0;
   bit           m_after_rst = 1'b0;
   int           m_wait = 0;
   logic [15:0]  m_target;
   logic [9:0]   m_id;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_update();
      if (rst) begin
         m_flits.delete();
         m_active    = 1'b0;
         m_err       = 1'b0;
         m_wait      = 0;
         m_after_rst = 1'b1;
         return;
      end
      m_after_rst = 1'b0;
      m_err       = 1'b0;
      if (!m_active) begin
         if (bus.pkt_valid) begin
            for (int k = 0; k < NF; k++) m_flits.push_back(bus.pkt_data[k*128 +: 128]);
            m_target = bus.pkt_target;
            m_id     = bus.pkt_id;
            m_active = 1'b1;
            m_wait   = 0;
         end
      end else if (m_flits.size() > 0) begin
         if (bus.req_data_ready) void'(m_flits.pop_front());
      end else if (bus.req_complete) begin
         m_active = 1'b0;
      end else if (m_wait == TO - 1) begin
         m_err    = 1'b1;
         m_active = 1'b0;
      end else begin
         m_wait++;
      end
   endtask

   task automatic check_all();
      chk("req_valid", 128'(bus.req_valid), 128'(m_active));
      chk("req_data_valid", 128'(bus.req_data_valid), 128'(m_flits.size() > 0));
      chk("busy", 128'(busy), 128'(m_active));
      chk("err_timeout", 128'(err_timeout), 128'(m_err));
      chk("pkt_accept", 128'(bus.pkt_accept), 128'(!m_active && !rst));
      chk("req_error", 128'(bus.req_error), 128'(0));
      if (m_flits.size() > 0) chk("req_data", bus.req_data, m_flits[0]);
      if (m_active) begin
         chk("req_type", 128'(bus.req_type), 128'(MT));
         chk("req_length", 128'(bus.req_length), 128'(NF * 16));
         chk("req_target", 128'(bus.req_target), 128'(m_target));
         chk("req_id", 128'(bus.req_id), 128'(m_id));
      end else if (m_after_rst) begin
         chk("rst_req_type", 128'(bus.req_type), 128'(0));
         chk("rst_req_length", 128'(bus.req_length), 128'(0));
         chk("rst_req_target", 128'(bus.req_target), 128'(0));
         chk("rst_req_id", 128'(bus.req_id), 128'(0));
         chk("rst_req_data", bus.req_data, 128'(0));
      end
   endtask

   // Inputs are set after a falling edge; one call advances exactly one clock.
   task automatic tick();
      if (bus.req_data_valid && bus.req_data_ready && !rst) beats++;
      if (bus.pkt_valid && bus.pkt_accept) accepts++;
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all();
      if (err_timeout) errs++;
   endtask

   task automatic load(input logic [15:0] t, input logic [9:0] id, input logic [127:0] base);
      bus.pkt_target = t;
      bus.pkt_id     = id;
      for (int k = 0; k < NF; k++) bus.pkt_data[k*128 +: 128] = base + 128'(k);
   endtask

   task automatic wait_for_wait_state(input string name);
      int n = 0;
      while (!(bus.req_valid && !bus.req_data_valid) && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) begin
         errors++;
         checks++;
         $display("FAIL %s: wait state not reached within 20 cycles", name);
      end
   endtask

   task automatic drain();
      bus.pkt_valid      = 1'b0;
      bus.req_data_ready = 1'b1;
      for (int i = 0; i < 40 && busy; i++) begin
         bus.req_complete = bus.req_valid && !bus.req_data_valid;
         tick();
      end
      bus.req_complete = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      int vcnt, k;
      int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      bus.pkt_valid      = 1'b0;
      bus.pkt_data       = '0;
      bus.pkt_target     = '0;
      bus.pkt_id         = '0;
      bus.req_complete   = 1'b0;
      bus.req_data_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();
      tick();
      chk("reset_req_valid", 128'(bus.req_valid), 128'(0));
      chk("reset_busy", 128'(busy), 128'(0));
      rst = 1'b0;

      // 1: straight-through message, complete in the 4th wait cycle
      beats = 0;
      load(16'h0012, 10'h5, 128'hA0);
      bus.pkt_valid      = 1'b1;
      bus.req_data_ready = 1'b1;
      tick();
      bus.pkt_valid = 1'b0;
      chk("t1_first_flit", bus.req_data, 128'hA0);
      chk("t1_length", 128'(bus.req_length), 128'd64);
      chk("t1_target", 128'(bus.req_target), 128'h0012);
      chk("t1_id", 128'(bus.req_id), 128'd5);
      chk("t1_type", 128'(bus.req_type), 128'h03);
      vcnt = 0;
      for (int c = 1; c <= 12; c++) begin
         if (bus.req_valid) vcnt++;
         bus.req_complete = (c == 8);
         tick();
      end
      bus.req_complete = 1'b0;
      chk("t1_valid_cycles", 128'(vcnt), 128'd8);
      chk("t1_beats", 128'(beats), 128'd4);
      chk("t1_busy_after", 128'(busy), 128'(0));

      // 2: ready toggling 1,0,0,1,1,0,1
      beats = 0;
      load(16'h0034, 10'h6, 128'hB0);
      bus.pkt_valid      = 1'b1;
      bus.req_data_ready = 1'b0;
      tick();
      bus.pkt_valid = 1'b0;
      for (int i = 0; i < 7; i++) begin
         bus.req_data_ready = pat[i][0];
         tick();
      end
      chk("t2_beats", 128'(beats), 128'd4);
      chk("t2_in_wait", 128'(bus.req_data_valid), 128'(0));
      bus.req_complete = 1'b1;
      tick();
      bus.req_complete = 1'b0;
      chk("t2_done", 128'(bus.req_valid), 128'(0));

      // 3: timeout, then a fresh packet is accepted
      errs = 0;
      load(16'h0101, 10'h7, 128'hC0);
      bus.pkt_valid      = 1'b1;
      bus.req_data_ready = 1'b1;
      tick();
      bus.pkt_valid = 1'b0;
      wait_for_wait_state("t3_enter_wait");
      k = 0;
      while (!err_timeout && k < 40) begin
         tick();
         k++;
      end
      chk("t3_timeout_delay", 128'(k), 128'd16);
      chk("t3_valid_low", 128'(bus.req_valid), 128'(0));
      tick();
      tick();
      chk("t3_err_pulses", 128'(errs), 128'd1);
      chk("t3_accept_ready", 128'(bus.pkt_accept), 128'(1));
      bus.pkt_valid = 1'b1;
      tick();
      bus.pkt_valid = 1'b0;
      chk("t3_new_msg", 128'(bus.req_valid), 128'(1));
      drain();

      // 4: pkt_valid held for two back-to-back packets
      accepts = 0;
      load(16'h0044, 10'h11, 128'hD0);
      bus.pkt_valid      = 1'b1;
      bus.req_data_ready = 1'b1;
      bus.req_complete   = 1'b1;
      tick();
      load(16'h0055, 10'h12, 128'hD8);
      k = 0;
      while (accepts < 2 && k < 20) begin
         tick();
         k++;
      end
      bus.pkt_valid    = 1'b0;
      bus.req_complete = 1'b0;
      chk("t4_accepts", 128'(accepts), 128'd2);
      chk("t4_second_target", 128'(bus.req_target), 128'h0055);
      chk("t4_second_flit0", bus.req_data, 128'hD8);
      drain();

      // 5: reset after the second beat
      load(16'h0066, 10'h21, 128'hE0);
      bus.pkt_valid      = 1'b1;
      bus.req_data_ready = 1'b1;
      tick();
      bus.pkt_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("t5_req_valid", 128'(bus.req_valid), 128'(0));
      chk("t5_req_data_valid", 128'(bus.req_data_valid), 128'(0));
      chk("t5_pkt_accept", 128'(bus.pkt_accept), 128'(1));
      load(16'h0077, 10'h22, 128'hE8);
      bus.pkt_valid = 1'b1;
      tick();
      bus.pkt_valid = 1'b0;
      chk("t5_restart_flit0", bus.req_data, 128'hE8);
      drain();

      // 6: stray complete in data phase, then complete coinciding with timeout
      errs = 0;
      load(16'h0088, 10'h31, 128'hF0);
      bus.pkt_valid      = 1'b1;
      bus.req_data_ready = 1'b1;
      tick();
      bus.pkt_valid    = 1'b0;
      bus.req_complete = 1'b1;
      tick();
      bus.req_complete = 1'b0;
      chk("t6_ignored_complete", 128'(bus.req_valid), 128'(1));
      wait_for_wait_state("t6_enter_wait");
      for (int i = 0; i < TO - 1; i++) tick();
      bus.req_complete = 1'b1;
      tick();
      bus.req_complete = 1'b0;
      chk("t6_err", 128'(err_timeout), 128'(0));
      chk("t6_valid_low", 128'(bus.req_valid), 128'(0));
      chk("t6_err_count", 128'(errs), 128'(0));

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         rst                = ($urandom_range(0, 199) == 0);
         bus.pkt_valid      = ($urandom_range(0, 2) == 0);
         bus.req_data_ready = 1'($urandom_range(0, 1));
         bus.req_complete   = ($urandom_range(0, 19) == 0);
         bus.pkt_target     = 16'($urandom());
         bus.pkt_id         = 10'($urandom());
         for (int w = 0; w < NF * 4; w++) bus.pkt_data[w*32 +: 32] = $urandom();
         tick();
      end
      rst = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
